robertsons_arbiter: RTL and testbench

Round-robin controller that shares one Robertson's multiplier core (toprobertsons) among NREQ requesters. It accepts signed operand pairs over a per-requester req/gnt handshake and launches the core with a one-cycle start pulse. It waits for the core's done, then returns the signed product with a per-requester response strobe. A watchdog aborts a hung core and returns an error response.

---
 rtl/robertsons_arbiter.sv | 115 +++++++++++
 tb/tb_robertsons_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/robertsons_arbiter.sv
// Round-robin front end that shares one Robertson's multiplier core among NREQ requesters.
// A watchdog turns a hung core into an error response.
module robertsons_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [2*WIDTH-1:0]      rsp_product,
    output logic                    rsp_err,
    output logic                    busy,
    output logic                    mul_start,
    output logic [WIDTH-1:0]        mul_multiplier,
    output logic [WIDTH-1:0]        mul_multiplicand,
    input  logic [2*WIDTH-1:0]      mul_product,
    input  logic                    mul_done
);

    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] rr_ptr, idx, sel;
    logic          any_req;
    logic [TW-1:0] timer;
    logic          err_q;
    logic          done_ok, timeout_hit;

    // timer == 0 marks the first WAIT cycle, where mul_done may still be left over from the last op.
    assign done_ok     = (state == WAIT) && (timer != '0) && mul_done;
    assign timeout_hit = (state == WAIT) && (timer == TW'(TIMEOUT - 1));

    // Scan downward so the requester closest to rr_ptr is the last, and winning, assignment.
    always_comb begin
        logic [IW:0] j;
        // NOTE: defaults first; any path that skipped an assignment would otherwise infer a latch.
        sel     = '0;
        any_req = 1'b0;
        j       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = {1'b0, rr_ptr} + (IW+1)'(k);
            if (j >= (IW+1)'(NREQ)) j = j - (IW+1)'(NREQ);
            if (req[j[IW-1:0]]) begin
                sel     = j[IW-1:0];
                any_req = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT:    if (done_ok || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
        if (reset) begin
            rr_ptr           <= '0;
            idx              <= '0;
            timer            <= '0;
            err_q            <= 1'b0;
            rsp_product      <= '0;
            mul_multiplier   <= '0;
            mul_multiplicand <= '0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    idx              <= sel;
                    mul_multiplier   <= req_a[int'(sel)*WIDTH +: WIDTH];
                    mul_multiplicand <= req_b[int'(sel)*WIDTH +: WIDTH];
                end
                START: timer <= '0;
                WAIT: begin
                    timer <= timer + 1'b1;
                    // Checking done first lets a completion win over a same-cycle timeout.
                    if (done_ok) begin
                        rsp_product <= mul_product;
                        err_q       <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_product <= '0;
                        err_q       <= 1'b1;
                    end
                end
                RESP: rr_ptr <= (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
                default: ;
            endcase
        end
    end

    assign gnt       = (state == START) ? (NREQ'(1) << idx) : '0;
    assign rsp_valid = (state == RESP)  ? (NREQ'(1) << idx) : '0;
    assign rsp_err   = (state == RESP) && err_q;
    assign mul_start = (state == START);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_robertsons_arbiter.sv
// Randomized scoreboard bench for robertsons_arbiter with a behavioural multiplier core
// whose latency, stale-done and hang behaviour are configurable.
module tb_robertsons_arbiter;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 16;
    localparam int PW      = 2 * WIDTH;
    localparam int DEPTH   = 64;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] req_a = '0, req_b = '0;
    logic [NREQ-1:0]       gnt, rsp_valid;
    logic [PW-1:0]         rsp_product;
    logic                  rsp_err, busy, mul_start;
    logic [WIDTH-1:0]      mul_multiplier, mul_multiplicand;
    logic [PW-1:0]         mul_product;
    logic                  mul_done;

    robertsons_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_product(rsp_product), .rsp_err(rsp_err),
        .busy(busy), .mul_start(mul_start), .mul_multiplier(mul_multiplier),
        .mul_multiplicand(mul_multiplicand), .mul_product(mul_product), .mul_done(mul_done)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_err    = 0;
    longint cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // ---------------- requesters: per-requester operation FIFOs ----------------
    logic [WIDTH-1:0] tab_a [NREQ][DEPTH];
    logic [WIDTH-1:0] tab_b [NREQ][DEPTH];
    int               head [NREQ];
    int               tail [NREQ];
    logic [NREQ-1:0]  gnt_s = '0;

    task automatic push(input int i, input int a, input int b);
        tab_a[i][tail[i] % DEPTH] = WIDTH'(a);
        tab_b[i][tail[i] % DEPTH] = WIDTH'(b);
        tail[i]++;
    endtask

    always @(negedge clk) gnt_s <= gnt;

    // Hold req and operands until gnt, then move on; idle requesters drive noise operands.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_s[i] && head[i] != tail[i]) head[i]++;
            if (head[i] != tail[i]) begin
                req[i] = 1'b1;
                req_a[i*WIDTH +: WIDTH] = tab_a[i][head[i] % DEPTH];
                req_b[i*WIDTH +: WIDTH] = tab_b[i][head[i] % DEPTH];
            end else begin
                req[i] = 1'b0;
                req_a[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                req_b[i*WIDTH +: WIDTH] = WIDTH'($urandom);
            end
        end
    end

    // ---------------- behavioural core: done rises lat cycles after start ----------------
    int            core_lat   = 4;   // 0 = never completes
    bit            core_stale = 1'b0; // keep the previous done high into the first WAIT cycle
    int            c_lat, c_k;
    bit            c_pend;
    logic [PW-1:0] c_prod, core_prod_now;

    assign core_prod_now = PW'(int'($signed(mul_multiplier)) * int'($signed(mul_multiplicand)));

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_done <= 1'b0; mul_product <= '0; c_pend <= 1'b0; c_k <= 0; c_lat <= 0; c_prod <= '0;
        end else if (mul_start) begin
            c_prod <= core_prod_now;
            if (core_lat == 1) begin
                mul_done <= 1'b1; mul_product <= core_prod_now; c_pend <= 1'b0;
            end else begin
                c_pend <= 1'b1; c_k <= 1; c_lat <= core_lat;
                if (!core_stale) mul_done <= 1'b0;
            end
        end else if (c_pend) begin
            c_k <= c_k + 1;
            if (c_k + 1 == c_lat) begin
                mul_done <= 1'b1; mul_product <= c_prod; c_pend <= 1'b0;
            end else begin
                mul_done <= 1'b0;
            end
        end
    end

    // ---------------- reference model: transaction timing relative to the grant ----------------
    typedef struct {
        longint           at;
        int               idx;
        logic [WIDTH-1:0] a, b;
        logic [PW-1:0]    prod;
        bit               err;
    } exp_t;

    exp_t   exp_gnt_q[$];
    exp_t   exp_rsp_q[$];
    exp_t   cur;
    bit     m_active = 1'b0;
    longint m_gcyc   = 0;
    longint m_resume = 0;
    int     m_ptr    = 0;

    always @(negedge clk) begin
        if (reset) begin
            m_active = 1'b0; m_resume = 0; m_ptr = 0;
            exp_gnt_q.delete(); exp_rsp_q.delete();
        end else if (!m_active) begin
            if (cyc >= m_resume && req != '0) begin
                int sel;
                sel = -1;
                for (int k = 0; k < NREQ; k++) begin
                    int j;
                    j = (m_ptr + k) % NREQ;
                    if (sel < 0 && req[j]) sel = j;
                end
                cur.idx  = sel;
                cur.a    = req_a[sel*WIDTH +: WIDTH];
                cur.b    = req_b[sel*WIDTH +: WIDTH];
                cur.prod = PW'(int'($signed(cur.a)) * int'($signed(cur.b)));
                cur.err  = 1'b0;
                cur.at   = cyc + 1;
                exp_gnt_q.push_back(cur);
                m_active = 1'b1;
                m_gcyc   = cyc + 1;
            end
        end else begin
            int   w;
            exp_t e;
            w = int'(cyc - m_gcyc);
            if ((w >= 2 && mul_done) || w == TIMEOUT) begin
                e    = cur;
                e.at = cyc + 1;
                if (!(w >= 2 && mul_done)) begin
                    e.err  = 1'b1;
                    e.prod = '0;
                end
                exp_rsp_q.push_back(e);
                m_active = 1'b0;
                m_resume = cyc + 2;
                m_ptr    = (cur.idx + 1) % NREQ;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (reset) begin
            check("reset_outputs", 64'({gnt, rsp_valid, rsp_product, rsp_err, busy, mul_start,
                                        mul_multiplier, mul_multiplicand}), 64'(0));
        end else begin
            exp_t e;
            logic [NREQ-1:0] oh;
            if (exp_gnt_q.size() > 0 && exp_gnt_q[0].at == cyc) begin
                e  = exp_gnt_q.pop_front();
                oh = '0; oh[e.idx] = 1'b1;
                check("gnt", 64'(gnt), 64'(oh));
                check("mul_start", 64'(mul_start), 64'(1));
                check("mul_operands", 64'({mul_multiplier, mul_multiplicand}), 64'({e.a, e.b}));
                check("busy_start", 64'(busy), 64'(1));
            end else if (gnt != '0 || mul_start) begin
                check("gnt_unexpected", 64'({gnt, mul_start}), 64'(0));
            end
            if (exp_rsp_q.size() > 0 && exp_rsp_q[0].at == cyc) begin
                e  = exp_rsp_q.pop_front();
                oh = '0; oh[e.idx] = 1'b1;
                check("rsp_valid", 64'(rsp_valid), 64'(oh));
                check("rsp_err", 64'(rsp_err), 64'(e.err));
                check("rsp_product", 64'(rsp_product), 64'(e.prod));
                check("operands_held", 64'({mul_multiplier, mul_multiplicand}), 64'({e.a, e.b}));
                check("busy_resp", 64'(busy), 64'(1));
            end else if (rsp_valid != '0 || rsp_err) begin
                check("rsp_unexpected", 64'({rsp_valid, rsp_err}), 64'(0));
            end
        end
    end

    // ---------------- sequencing ----------------
    function automatic bit all_idle();
        bit r;
        r = !m_active && exp_gnt_q.size() == 0 && exp_rsp_q.size() == 0;
        for (int i = 0; i < NREQ; i++) if (head[i] != tail[i]) r = 1'b0;
        return r;
    endfunction

    task automatic drain(input int budget);
        int n;
        n = 0;
        @(posedge clk);
        while (!all_idle() && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n >= budget) fail_now("drain_timeout");
        @(negedge clk);
        check("busy_idle", 64'(busy), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        // single request, long latency
        core_lat = 9;
        push(0, 5, 6);
        drain(200);

        // two simultaneous requests
        core_lat = 5;
        push(0, 7, -5);
        push(1, -5, 6);
        drain(200);

        // all four held continuously: fairness and extreme operands
        core_lat = 3;
        for (int r = 0; r < 2; r++) begin
            push(0, -7, 8); push(1, -5, -6); push(2, -9, -4); push(3, -128, -128);
        end
        drain(400);

        // hung core, then normal service; then done exactly at the timeout boundary
        core_lat = 0;
        push(2, 3, 3);
        drain(200);
        core_lat = 4;
        push(3, 12, -11);
        drain(200);
        core_lat = TIMEOUT;
        push(1, 100, 100);
        drain(200);

        // stale done from the previous op held through the first WAIT cycle
        core_lat = 3;
        push(0, 10, 3);
        drain(200);
        core_lat = 7; core_stale = 1'b1;
        push(0, -3, 11);
        drain(200);
        core_lat = 2;
        push(1, 4, -4);
        drain(200);
        core_stale = 1'b0;

        // reset during WAIT; afterwards the round-robin pointer must be back at 0
        core_lat = 3;
        push(2, 1, 1);
        drain(200);
        core_lat = 0;
        push(1, 9, -3);
        n = 0;
        while (!(m_active && cyc >= m_gcyc + 3) && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n >= 200) fail_now("wait_for_wait_state");
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        core_lat = 4;
        push(1, 9, -3);
        push(3, 2, 2);
        drain(200);

        // randomized rounds
        for (int r = 0; r < 25; r++) begin
            core_lat   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
            core_stale = (core_lat != 0) && ($urandom_range(0, 3) == 0);
            n = 0;
            for (int i = 0; i < NREQ; i++) begin
                int cnt;
                cnt = $urandom_range(0, 2);
                for (int k = 0; k < cnt; k++) begin
                    push(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
                    n++;
                end
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
            if (n == 0) push(int'($urandom_range(0, NREQ - 1)), -128, 127);
            drain(2000);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
